// File: rtl/rc4_decrypt_core_if.sv
// Bus bundle between the RC4 decrypt core and its sequencer / memories.
//
// Groups the start/status handshake together with the three memory ports the
// core drives:
//   start            sequencer -> core   1-cycle start pulse
//   busy/done        core -> sequencer   run status (levels)
//   key_invalid      core -> sequencer   decrypted byte failed the ASCII check
//   s_addr/s_wdata/s_wren, s_rdata       S memory (sync read, 1-cycle latency)
//   enc_addr, enc_rdata                  encrypted-message ROM (sync read)
//   dec_addr/dec_wdata/dec_wren          decrypted-message RAM
//
// Modports:
//   slave  - the decrypt core
//   master - whatever drives start and owns the memories (sequencer / bench)
interface rc4_decrypt_core_if #(
  parameter int unsigned MSG_AW = 5
);
  logic              start;
  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [MSG_AW-1:0] enc_addr;
  logic [7:0]        enc_rdata;
  logic [MSG_AW-1:0] dec_addr;
  logic [7:0]        dec_wdata;
  logic              dec_wren;
  logic              busy;
  logic              done;
  logic              key_invalid;

  modport slave (
    input  start,
    input  s_rdata,
    input  enc_rdata,
    output s_addr,
    output s_wdata,
    output s_wren,
    output enc_addr,
    output dec_addr,
    output dec_wdata,
    output dec_wren,
    output busy,
    output done,
    output key_invalid
  );

  modport master (
    output start,
    output s_rdata,
    output enc_rdata,
    input  s_addr,
    input  s_wdata,
    input  s_wren,
    input  enc_addr,
    input  dec_addr,
    input  dec_wdata,
    input  dec_wren,
    input  busy,
    input  done,
    input  key_invalid
  );
endinterface

// File: rtl/rc4_decrypt_core.sv
// RC4 keystream generation (PRGA) and decrypt stage.
//
// After the sequencer has shuffled S (KSA) it pulses start. The core then walks
// S, producing one keystream byte per message byte, XORs it with the encrypted
// ROM byte and writes the plaintext into the decrypted RAM. When all MSG_LEN
// bytes are written it raises done.
//
// Ports:
//   CLOCK_50  in   system clock, all state on the rising edge
//   reset     in   asynchronous, active-high reset
//   bus       slave modport of rc4_decrypt_core_if (start, status, memory ports)
//
// Parameters:
//   MSG_LEN   message length in bytes (1..256)
//   MSG_AW    message address width, $clog2(MSG_LEN) with a minimum of 1
//
// Optional feature (compile-time macro RC4_ASCII_CHECK_EN):
//   When defined, each decrypted byte must be a space or 'a'..'z'. The first
//   byte that is not suppresses its RAM write and sends the core to FAIL
//   (done and key_invalid high), so a key search can drop a wrong key early.
//   When undefined, every byte is written and key_invalid is tied low.
//
// Timing: every output is a register loaded from a decode of the current
// state and datapath registers, so bus activity lags the state by one cycle.
// The WAIT states absorb that lag plus the 1-cycle memory read latency: data
// for an address decoded in FETCH_x is on s_rdata/enc_rdata during LATCH_x
// (or WRITE_DEC). Each byte takes 11 states; done rises 11*MSG_LEN+1 cycles
// after the start edge.
module rc4_decrypt_core #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned MSG_AW  = 5
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  rc4_decrypt_core_if.slave     bus
);

  localparam int unsigned   KW    = MSG_AW + 1;
  localparam logic [KW-1:0] KLast = KW'(MSG_LEN - 1);
  localparam logic [KW-1:0] KOne  = KW'(1);

  typedef enum logic [3:0] {
    StIdle,
    StFetchSi,
    StWaitSi,
    StLatchSi,
    StFetchSj,
    StWaitSj,
    StLatchSj,
    StWriteI,
    StWriteJ,
    StFetchF,
    StWaitF,
    StWriteDec,
    StDone,
    StFail
  } state_e;

  state_e state_q, state_d;

  // Datapath registers
  logic [7:0]    i_q, i_d;
  logic [7:0]    j_q, j_d;
  logic [7:0]    si_q, si_d;
  logic [7:0]    sj_q, sj_d;
  logic [KW-1:0] k_q, k_d;

  // Registered outputs
  logic [7:0]        s_addr_q, s_addr_d;
  logic [7:0]        s_wdata_q, s_wdata_d;
  logic              s_wren_q, s_wren_d;
  logic [MSG_AW-1:0] enc_addr_q, enc_addr_d;
  logic [MSG_AW-1:0] dec_addr_q, dec_addr_d;
  logic [7:0]        dec_wdata_q, dec_wdata_d;
  logic              dec_wren_q, dec_wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              key_inv_q, key_inv_d;

  logic       start_acc;
  logic       stopped;
  logic [7:0] dec_byte;
  logic [7:0] f_addr;
  logic       byte_ok;

  // start is only honoured while stopped; during a run it has no effect.
  assign stopped   = (state_q == StIdle) || (state_q == StDone) || (state_q == StFail);
  assign start_acc = bus.start && stopped;
  assign dec_byte  = bus.s_rdata ^ bus.enc_rdata;
  assign f_addr    = si_q + sj_q;

`ifdef RC4_ASCII_CHECK_EN
  assign byte_ok = (dec_byte == 8'h20) || ((dec_byte >= 8'h61) && (dec_byte <= 8'h7A));
`else
  assign byte_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    k_d         = k_q;

    s_addr_d    = 8'h00;
    s_wdata_d   = 8'h00;
    s_wren_d    = 1'b0;
    enc_addr_d  = '0;
    dec_addr_d  = '0;
    dec_wdata_d = 8'h00;
    dec_wren_d  = 1'b0;

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start_acc) begin
          state_d = StFetchSi;
          i_d     = 8'd1;
          j_d     = 8'd0;
          k_d     = '0;
        end
      end
      StFetchSi: begin
        s_addr_d = i_q;
        state_d  = StWaitSi;
      end
      StWaitSi: begin
        s_addr_d = i_q;
        state_d  = StLatchSi;
      end
      StLatchSi: begin
        s_addr_d = i_q;
        si_d     = bus.s_rdata;
        j_d      = j_q + bus.s_rdata;
        state_d  = StFetchSj;
      end
      StFetchSj: begin
        s_addr_d = j_q;
        state_d  = StWaitSj;
      end
      StWaitSj: begin
        s_addr_d = j_q;
        state_d  = StLatchSj;
      end
      StLatchSj: begin
        s_addr_d = j_q;
        sj_d     = bus.s_rdata;
        state_d  = StWriteI;
      end
      // Swap S[i] and S[j]. When i == j both writes carry the same value.
      StWriteI: begin
        s_addr_d  = i_q;
        s_wdata_d = sj_q;
        s_wren_d  = 1'b1;
        state_d   = StWriteJ;
      end
      StWriteJ: begin
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
        state_d   = StFetchF;
      end
      StFetchF: begin
        s_addr_d   = f_addr;
        enc_addr_d = k_q[MSG_AW-1:0];
        state_d    = StWaitF;
      end
      StWaitF: begin
        s_addr_d   = f_addr;
        enc_addr_d = k_q[MSG_AW-1:0];
        state_d    = StWriteDec;
      end
      StWriteDec: begin
        s_addr_d    = f_addr;
        enc_addr_d  = k_q[MSG_AW-1:0];
        dec_addr_d  = k_q[MSG_AW-1:0];
        dec_wdata_d = dec_byte;
        dec_wren_d  = byte_ok;
        i_d         = i_q + 8'd1;
        k_d         = k_q + KOne;
        if (!byte_ok) begin
          state_d = StFail;
        end else if (k_q == KLast) begin
          state_d = StDone;
        end else begin
          state_d = StFetchSi;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = !stopped;
    // Status levels drop on the same edge that accepts a restart.
    done_d = ((state_q == StDone) || (state_q == StFail)) && !start_acc;
`ifdef RC4_ASCII_CHECK_EN
    key_inv_d = (state_q == StFail) && !start_acc;
`else
    key_inv_d = 1'b0;
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      i_q         <= 8'h00;
      j_q         <= 8'h00;
      si_q        <= 8'h00;
      sj_q        <= 8'h00;
      k_q         <= '0;
      s_addr_q    <= 8'h00;
      s_wdata_q   <= 8'h00;
      s_wren_q    <= 1'b0;
      enc_addr_q  <= '0;
      dec_addr_q  <= '0;
      dec_wdata_q <= 8'h00;
      dec_wren_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_inv_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      k_q         <= k_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wren_q    <= s_wren_d;
      enc_addr_q  <= enc_addr_d;
      dec_addr_q  <= dec_addr_d;
      dec_wdata_q <= dec_wdata_d;
      dec_wren_q  <= dec_wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_inv_q   <= key_inv_d;
    end
  end

  assign bus.s_addr      = s_addr_q;
  assign bus.s_wdata     = s_wdata_q;
  assign bus.s_wren      = s_wren_q;
  assign bus.enc_addr    = enc_addr_q;
  assign bus.dec_addr    = dec_addr_q;
  assign bus.dec_wdata   = dec_wdata_q;
  assign bus.dec_wren    = dec_wren_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.key_invalid = key_inv_q;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: behavioural S memory / ROM models, an RC4 model
// that pushes expected plaintext into a scoreboard queue at start, and a
// negedge monitor that pops and compares every decrypted RAM write.
module tb_rc4_decrypt_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_decrypt_core_if #(.MSG_AW(5)) b32 ();
  rc4_decrypt_core_if #(.MSG_AW(4)) b9 ();

  rc4_decrypt_core #(.MSG_LEN(32), .MSG_AW(5)) u_dut32 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (b32)
  );

  rc4_decrypt_core #(.MSG_LEN(9), .MSG_AW(4)) u_dut9 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (b9)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memories (sync read, 1-cycle latency), bulk-loadable from *_init.
  logic [7:0] s32_mem [256];
  logic [7:0] s32_init [256];
  logic [7:0] e32_rom [32];
  logic       ld32 = 1'b0;
  logic [7:0] s9_mem [256];
  logic [7:0] s9_init [256];
  logic [7:0] e9_rom [16];
  logic       ld9 = 1'b0;

  always @(posedge clk) begin
    if (ld32) s32_mem <= s32_init;
    else if (b32.s_wren) s32_mem[b32.s_addr] <= b32.s_wdata;
    b32.s_rdata   <= s32_mem[b32.s_addr];
    b32.enc_rdata <= e32_rom[b32.enc_addr];
  end

  always @(posedge clk) begin
    if (ld9) s9_mem <= s9_init;
    else if (b9.s_wren) s9_mem[b9.s_addr] <= b9.s_wdata;
    b9.s_rdata   <= s9_mem[b9.s_addr];
    b9.enc_rdata <= e9_rom[b9.enc_addr];
  end

  // Scoreboards: entries are {addr, data}.
  logic [15:0] q32[$];
  logic [15:0] q9[$];
  logic [15:0] e32_ent, e9_ent;
  int swr32 = 0, dw32 = 0, swr9 = 0, dw9 = 0;
  int kinv32 = 0, kinv9 = 0;

  always @(negedge clk) begin
    if (b32.s_wren) swr32++;
    if (b32.key_invalid) kinv32++;
    if (b32.dec_wren) begin
      dw32++;
      if (q32.size() == 0) begin
        check("dec32_unexpected_write", 32'd1, 32'd0);
      end else begin
        e32_ent = q32.pop_front();
        check("dec32_addr", 32'(b32.dec_addr), 32'(e32_ent[15:8]));
        check("dec32_data", 32'(b32.dec_wdata), 32'(e32_ent[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (b9.s_wren) swr9++;
    if (b9.key_invalid) kinv9++;
    if (b9.dec_wren) begin
      dw9++;
      if (q9.size() == 0) begin
        check("dec9_unexpected_write", 32'd1, 32'd0);
      end else begin
        e9_ent = q9.pop_front();
        check("dec9_addr", 32'(b9.dec_addr), 32'(e9_ent[15:8]));
        check("dec9_data", 32'(b9.dec_wdata), 32'(e9_ent[7:0]));
      end
    end
  end

  // RC4 model state for the 32-byte instance.
  logic [7:0] m_s [256];

  task automatic model_identity();
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
  endtask

  task automatic model_push32();
    logic [7:0] mi, mj, t, f;
    mi = 8'd0;
    mj = 8'd0;
    for (int n = 0; n < 32; n++) begin
      mi = mi + 8'd1;
      mj = mj + m_s[mi];
      t = m_s[mi];
      m_s[mi] = m_s[mj];
      m_s[mj] = t;
      f = m_s[mi] + m_s[mj];
      q32.push_back({8'(n), m_s[f] ^ e32_rom[n]});
    end
  endtask

  task automatic load_identity32();
    for (int x = 0; x < 256; x++) s32_init[x] = 8'(x);
    ld32 = 1'b1;
    @(negedge clk);
    ld32 = 1'b0;
  endtask

  task automatic check_s32(input string tag);
    int bad;
    bad = 0;
    for (int x = 0; x < 256; x++) if (s32_mem[x] !== m_s[x]) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  // Pulse start, optionally re-pulse 20 cycles in, and wait for done.
  // lat = cycles from the accepting edge to the edge where done rose.
  task automatic run32(input bit second, output int lat, output int busy_n);
    swr32 = 0;
    dw32  = 0;
    b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    check("start_clears_done", 32'(b32.done), 32'd0);
    check("start_clears_kinv", 32'(b32.key_invalid), 32'd0);
    lat = 0;
    busy_n = 0;
    while (b32.done !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (b32.busy === 1'b1) busy_n++;
      b32.start = second && (lat == 20);
    end
    b32.start = 1'b0;
  endtask

  int lat, busy_n, c;
  logic [7:0] key [3];
  logic [7:0] pt [9];
  logic [7:0] enc9v [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    b32.start = 1'b0;
    b9.start  = 1'b0;
    for (int x = 0; x < 32; x++) e32_rom[x] = 8'h00;
    for (int x = 0; x < 16; x++) e9_rom[x] = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(b32.busy), 32'd0);
    check("rst_done", 32'(b32.done), 32'd0);
    check("rst_kinv", 32'(b32.key_invalid), 32'd0);
    check("rst_s_wren", 32'(b32.s_wren), 32'd0);
    check("rst_dec_wren", 32'(b32.dec_wren), 32'd0);
    check("rst_s_addr", 32'(b32.s_addr), 32'd0);
    check("rst_enc_addr", 32'(b32.enc_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

`ifndef RC4_ASCII_CHECK_EN
    // Identity S, zero ciphertext; a second start mid-run must be ignored.
    load_identity32();
    model_identity();
    model_push32();
    run32(1'b1, lat, busy_n);
    check("run1_done_latency", 32'(lat), 32'd353);
    check("run1_busy_cycles", 32'(busy_n), 32'd352);
    check("run1_s_wren_count", 32'(swr32), 32'd64);
    check("run1_dec_wren_count", 32'(dw32), 32'd32);
    check("run1_queue_left", 32'(q32.size()), 32'd0);
    check_s32("run1_final_s");

    // Restart straight from DONE on the already permuted S.
    model_push32();
    run32(1'b0, lat, busy_n);
    check("restart_done_latency", 32'(lat), 32'd353);
    check("restart_dec_wren_count", 32'(dw32), 32'd32);
    check("restart_queue_left", 32'(q32.size()), 32'd0);
    check_s32("restart_final_s");
    check("restart_kinv_never", 32'(kinv32), 32'd0);

    // Reset in the middle of byte 5's first S write, then a clean rerun.
    load_identity32();
    model_identity();
    model_push32();
    b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    c = 0;
    lat = 0;
    while (c < 11 && lat < 500) begin
      @(negedge clk);
      lat++;
      if (b32.s_wren === 1'b1) c++;
    end
    check("midrst_reached_byte5", 32'(c), 32'd11);
    reset = 1'b1;
    #1;
    check("midrst_s_wren", 32'(b32.s_wren), 32'd0);
    check("midrst_s_addr", 32'(b32.s_addr), 32'd0);
    check("midrst_busy", 32'(b32.busy), 32'd0);
    check("midrst_done", 32'(b32.done), 32'd0);
    check("midrst_dec_writes_before", 32'(32 - q32.size()), 32'd5);
    q32.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_identity32();
    model_identity();
    model_push32();
    run32(1'b0, lat, busy_n);
    check("postrst_done_latency", 32'(lat), 32'd353);
    check("postrst_dec_wren_count", 32'(dw32), 32'd32);
    check("postrst_s_wren_count", 32'(swr32), 32'd64);
    check("postrst_queue_left", 32'(q32.size()), 32'd0);
    check_s32("postrst_final_s");

    // Key "Key" -> "Plaintext" on the 9-byte instance.
    key   = '{8'h4B, 8'h65, 8'h79};
    pt    = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    enc9v = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    begin
      logic [7:0] kj, t;
      for (int x = 0; x < 256; x++) s9_init[x] = 8'(x);
      kj = 8'd0;
      for (int x = 0; x < 256; x++) begin
        kj = kj + s9_init[x] + key[x % 3];
        t = s9_init[x];
        s9_init[x] = s9_init[kj];
        s9_init[kj] = t;
      end
    end
    for (int x = 0; x < 9; x++) begin
      e9_rom[x] = enc9v[x];
      q9.push_back({8'(x), pt[x]});
    end
    ld9 = 1'b1;
    @(negedge clk);
    ld9 = 1'b0;
    swr9 = 0;
    dw9  = 0;
    b9.start = 1'b1;
    @(negedge clk);
    b9.start = 1'b0;
    lat = 0;
    while (b9.done !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check("key_done_latency", 32'(lat), 32'd100);
    check("key_dec_wren_count", 32'(dw9), 32'd9);
    check("key_s_wren_count", 32'(swr9), 32'd18);
    check("key_queue_left", 32'(q9.size()), 32'd0);
    check("key_kinv_never", 32'(kinv9), 32'd0);
`else
    // ASCII check: byte 0 = 0x02 fails immediately.
    load_identity32();
    run32(1'b0, lat, busy_n);
    check("ascii0_done_latency", 32'(lat), 32'd12);
    check("ascii0_kinv", 32'(b32.key_invalid), 32'd1);
    check("ascii0_busy", 32'(b32.busy), 32'd0);
    check("ascii0_dec_wren_count", 32'(dw32), 32'd0);

    // enc[0] = 0x63 makes byte 0 'a'; byte 1 (0x05) then fails.
    e32_rom[0] = 8'h63;
    load_identity32();
    q32.push_back({8'd0, 8'h61});
    run32(1'b0, lat, busy_n);
    check("ascii1_done_latency", 32'(lat), 32'd23);
    check("ascii1_kinv", 32'(b32.key_invalid), 32'd1);
    check("ascii1_dec_wren_count", 32'(dw32), 32'd1);
    check("ascii1_queue_left", 32'(q32.size()), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
